// File: rtl/rvsteel_spi_target.sv
// rvsteel_spi_target: SPI target with a memory-mapped register interface.
// SCLK, CS and PICO are oversampled and edge-detected in the clock domain.
module rvsteel_spi_target (
  input  logic        clock,
  input  logic        reset,
  input  logic [4:0]  rw_address,
  output logic [31:0] read_data,
  input  logic        read_request,
  output logic        read_response,
  input  logic [7:0]  write_data,
  input  logic [3:0]  write_strobe,
  input  logic        write_request,
  output logic        write_response,
  input  logic        sclk,
  input  logic        pico,
  output logic        poci,
  input  logic        cs,
  output logic        irq
);

  typedef enum logic {IDLE, ACTIVE} state_t;

  state_t state_q, state_d;

  logic       sclk_s1, sclk_s2, sclk_s3;
  logic       cs_s1, cs_s2, cs_s3;
  logic       pico_s1, pico_s2;
  logic       cpol, cpha;
  logic [7:0] tx_buffer, tx_shift, rx_data;
  logic [6:0] rx_shift;
  logic       rx_valid, overrun, tx_full;
  logic [2:0] bit_count;
  logic       poci_bit, poci_en;

  logic rise, fall, leading, trailing;
  logic select, deselect, busy, active;
  logic sample_en, shift_en, byte_done;
  logic rd_rdata, wr_ok;

  assign rise      = sclk_s2 & ~sclk_s3;
  assign fall      = ~sclk_s2 & sclk_s3;
  assign leading   = cpol ? fall : rise;
  assign trailing  = cpol ? rise : fall;
  assign select    = ~cs_s2 & cs_s3;
  assign deselect  = cs_s2 & ~cs_s3;
  assign busy      = ~cs_s2;
  assign active    = (state_q == ACTIVE) && !deselect;
  assign sample_en = active && (cpha ? trailing : leading);
  assign shift_en  = active && (cpha ? leading : trailing);
  assign byte_done = sample_en && (bit_count == 3'd7);
  assign rd_rdata  = read_request && (rw_address == 5'h0c);
  assign wr_ok     = write_request && (write_strobe == 4'hf);

  assign irq  = rx_valid;
  assign poci = poci_en ? poci_bit : 1'bz;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (select) state_d = ACTIVE;
      ACTIVE:  if (deselect) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sclk_s1        <= 1'b0;
      sclk_s2        <= 1'b0;
      sclk_s3        <= 1'b0;
      cs_s1          <= 1'b1;
      cs_s2          <= 1'b1;
      cs_s3          <= 1'b1;
      pico_s1        <= 1'b0;
      pico_s2        <= 1'b0;
      cpol           <= 1'b0;
      cpha           <= 1'b0;
      tx_buffer      <= 8'd0;
      tx_shift       <= 8'd0;
      rx_shift       <= 7'd0;
      rx_data        <= 8'd0;
      rx_valid       <= 1'b0;
      overrun        <= 1'b0;
      tx_full        <= 1'b0;
      bit_count      <= 3'd0;
      poci_bit       <= 1'b0;
      poci_en        <= 1'b0;
      read_data      <= 32'hdeadbeef;
      read_response  <= 1'b0;
      write_response <= 1'b0;
    end else begin
      sclk_s1 <= sclk;
      sclk_s2 <= sclk_s1;
      sclk_s3 <= sclk_s2;
      cs_s1   <= cs;
      cs_s2   <= cs_s1;
      cs_s3   <= cs_s2;
      pico_s1 <= pico;
      pico_s2 <= pico_s1;

      if (state_q == IDLE) begin
        bit_count <= 3'd0;
        if (select && !cpha) begin
          tx_shift <= tx_buffer;
          tx_full  <= 1'b0;
        end
      end else if (deselect) begin
        bit_count <= 3'd0;
      end else begin
        if (sample_en) begin
          rx_shift  <= {rx_shift[5:0], pico_s2};
          bit_count <= bit_count + 3'd1;
        end
        if (shift_en) begin
          if (bit_count == 3'd0) begin
            tx_shift <= tx_buffer;
            tx_full  <= 1'b0;
          end else begin
            tx_shift <= {tx_shift[6:0], 1'b0};
          end
        end
      end

      // A read racing completion consumes the old byte, so no overrun.
      if (byte_done) begin
        rx_data  <= {rx_shift, pico_s2};
        rx_valid <= 1'b1;
        overrun  <= rd_rdata ? 1'b0 : (overrun | rx_valid);
      end else if (rd_rdata) begin
        rx_valid <= 1'b0;
        overrun  <= 1'b0;
      end

      if (wr_ok) begin
        unique case (rw_address)
          5'h00: if (!busy) cpol <= write_data[0];
          5'h04: if (!busy) cpha <= write_data[0];
          5'h08: begin
            tx_buffer <= write_data;
            tx_full   <= 1'b1;
          end
          default: ;
        endcase
      end

      read_response  <= read_request;
      write_response <= write_request;
      if (read_request) begin
        unique case (rw_address)
          5'h00:   read_data <= {31'd0, cpol};
          5'h04:   read_data <= {31'd0, cpha};
          5'h0c:   read_data <= {24'd0, rx_data};
          5'h10:   read_data <= {28'd0, tx_full, overrun, rx_valid, busy};
          default: read_data <= 32'hdeadbeef;
        endcase
      end else begin
        read_data <= 32'hdeadbeef;
      end

      poci_bit <= tx_shift[7];
      poci_en  <= (state_q == ACTIVE);
    end
  end

endmodule

// File: tb/tb_rvsteel_spi_target.sv
// tb_rvsteel_spi_target: directed SPI controller model with byte scoreboards.
// POCI carries a pull-up so a released line reads as 1.
module tb_rvsteel_spi_target;

  localparam int HALF = 8;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic [4:0]  rw_address = 5'd0;
  logic [31:0] read_data;
  logic        read_request = 1'b0;
  logic        read_response;
  logic [7:0]  write_data = 8'd0;
  logic [3:0]  write_strobe = 4'h0;
  logic        write_request = 1'b0;
  logic        write_response;
  logic        sclk = 1'b0;
  logic        pico = 1'b0;
  wire         poci;
  logic        cs = 1'b1;
  logic        irq;

  pullup (poci);

  int n_assert = 0;
  int n_fail   = 0;

  logic       cpol_m = 1'b0;
  logic       cpha_m = 1'b0;
  logic [7:0] exp_tx_q[$];
  logic [7:0] exp_rx_q[$];
  logic [7:0] rx;
  logic [31:0] rd;

  rvsteel_spi_target dut (
    .clock          (clock),
    .reset          (reset),
    .rw_address     (rw_address),
    .read_data      (read_data),
    .read_request   (read_request),
    .read_response  (read_response),
    .write_data     (write_data),
    .write_strobe   (write_strobe),
    .write_request  (write_request),
    .write_response (write_response),
    .sclk           (sclk),
    .pico           (pico),
    .poci           (poci),
    .cs             (cs),
    .irq            (irq)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic bus_write(input logic [4:0] a, input logic [7:0] d,
                           input logic [3:0] s);
    rw_address    = a;
    write_data    = d;
    write_strobe  = s;
    write_request = 1'b1;
    @(negedge clock);
    write_request = 1'b0;
    chk("write_response", 32'(write_response), 32'd1);
    @(negedge clock);
  endtask

  task automatic bus_read(input logic [4:0] a, output logic [31:0] d);
    rw_address   = a;
    read_request = 1'b1;
    @(negedge clock);
    read_request = 1'b0;
    d = read_data;
    chk("read_response", 32'(read_response), 32'd1);
    @(negedge clock);
  endtask

  task automatic cs_low;
    cs = 1'b0;
    cyc(HALF);
  endtask

  task automatic cs_high;
    cyc(HALF);
    cs = 1'b1;
    repeat (4) @(posedge clock);
    @(negedge clock);
    chk("poci released", 32'(poci), 32'd1);
  endtask

  // mid: 0 none, 1 check tx_full clear, 2 write WDATA=mid_d
  task automatic spi_byte(input logic [7:0] tx, output logic [7:0] r,
                          input int nbits, input int mid,
                          input logic [7:0] mid_d);
    logic [31:0] st;
    r = 8'd0;
    for (int i = 7; i >= 8 - nbits; i--) begin
      if (!cpha_m) begin
        pico = tx[i];
        cyc(HALF);
        sclk = ~cpol_m;
        r[i] = poci;
      end else begin
        sclk = ~cpol_m;
        pico = tx[i];
      end
      if (i == 7 && mid != 0) begin
        cyc(4);
        if (mid == 1) begin
          bus_read(5'h10, st);
          chk("tx_full after lead", 32'(st[3]), 32'd0);
        end else begin
          bus_write(5'h08, mid_d, 4'hf);
        end
        cyc(HALF - 6);
      end else begin
        cyc(HALF);
      end
      sclk = cpol_m;
      if (cpha_m) begin
        r[i] = poci;
        cyc(HALF);
      end
    end
  endtask

  initial begin
    cyc(3);
    chk("rst read_data", read_data, 32'hdeadbeef);
    chk("rst read_response", 32'(read_response), 32'd0);
    chk("rst write_response", 32'(write_response), 32'd0);
    chk("rst poci", 32'(poci), 32'd1);
    chk("rst irq", 32'(irq), 32'd0);
    reset = 1'b1;
    cyc(2);
    bus_read(5'h10, rd);
    chk("rst status", rd, 32'd0);

    // mode 0
    bus_write(5'h08, 8'ha5, 4'hf);
    exp_tx_q.push_back(8'ha5);
    bus_read(5'h10, rd);
    chk("tx_full set", rd, 32'h8);
    chk("irq before m0", 32'(irq), 32'd0);
    cs_low();
    spi_byte(8'h3c, rx, 8, 0, 8'h00);
    exp_rx_q.push_back(8'h3c);
    chk("irq after m0", 32'(irq), 32'd1);
    cs_high();
    chk("m0 poci byte", 32'(rx), 32'(exp_tx_q.pop_front()));
    bus_read(5'h0c, rd);
    chk("m0 rdata", rd, 32'(exp_rx_q.pop_front()));
    chk("irq cleared", 32'(irq), 32'd0);
    bus_read(5'h10, rd);
    chk("m0 status", rd, 32'd0);

    // mode 3
    bus_write(5'h00, 8'h01, 4'hf);
    bus_write(5'h04, 8'h01, 4'hf);
    cpol_m = 1'b1;
    cpha_m = 1'b1;
    sclk   = 1'b1;
    cyc(4);
    bus_write(5'h08, 8'h81, 4'hf);
    exp_tx_q.push_back(8'h81);
    cs_low();
    spi_byte(8'h7e, rx, 8, 1, 8'h00);
    exp_rx_q.push_back(8'h7e);
    cs_high();
    chk("m3 poci byte", 32'(rx), 32'(exp_tx_q.pop_front()));
    bus_read(5'h0c, rd);
    chk("m3 rdata", rd, 32'(exp_rx_q.pop_front()));
    sclk = 1'b0;
    cyc(4);
    bus_write(5'h00, 8'h00, 4'hf);
    bus_write(5'h04, 8'h00, 4'hf);
    cpol_m = 1'b0;
    cpha_m = 1'b0;

    // back-to-back bytes
    bus_write(5'h08, 8'h11, 4'hf);
    exp_tx_q.push_back(8'h11);
    exp_tx_q.push_back(8'h22);
    cs_low();
    spi_byte(8'haa, rx, 8, 2, 8'h22);
    exp_rx_q.push_back(8'haa);
    chk("b2b byte0", 32'(rx), 32'(exp_tx_q.pop_front()));
    spi_byte(8'h55, rx, 8, 0, 8'h00);
    exp_rx_q.push_back(8'h55);
    chk("b2b byte1", 32'(rx), 32'(exp_tx_q.pop_front()));
    cs_high();
    bus_read(5'h10, rd);
    chk("b2b overrun status", rd, 32'h6);
    void'(exp_rx_q.pop_front());
    bus_read(5'h0c, rd);
    chk("b2b rdata", rd, 32'(exp_rx_q.pop_front()));
    bus_read(5'h10, rd);
    chk("b2b status cleared", 32'(rd[2:1]), 32'd0);

    // abort after 4 bits
    bus_write(5'h08, 8'hf0, 4'hf);
    cs_low();
    spi_byte(8'h99, rx, 4, 0, 8'h00);
    cyc(6);
    chk("abort poci driven", 32'(poci), 32'd0);
    cs_high();
    bus_read(5'h10, rd);
    chk("abort status", rd, 32'd0);
    bus_write(5'h08, 8'hc3, 4'hf);
    exp_tx_q.push_back(8'hc3);
    cs_low();
    spi_byte(8'h5a, rx, 8, 0, 8'h00);
    exp_rx_q.push_back(8'h5a);
    cs_high();
    chk("post-abort poci byte", 32'(rx), 32'(exp_tx_q.pop_front()));
    bus_read(5'h0c, rd);
    chk("post-abort rdata", rd, 32'(exp_rx_q.pop_front()));

    // registers
    cs_low();
    bus_read(5'h10, rd);
    chk("busy status", rd, 32'h1);
    bus_write(5'h00, 8'h01, 4'hf);
    bus_read(5'h00, rd);
    chk("cpol locked while busy", rd, 32'd0);
    cs_high();
    bus_write(5'h04, 8'h01, 4'h3);
    bus_read(5'h04, rd);
    chk("partial strobe ignored", rd, 32'd0);
    bus_read(5'h1c, rd);
    chk("unmapped read", rd, 32'hdeadbeef);
    rw_address   = 5'h00;
    read_request = 1'b1;
    chk("resp lag before", 32'(read_response), 32'd0);
    @(negedge clock);
    chk("resp lag during", 32'(read_response), 32'd1);
    read_request = 1'b0;
    @(negedge clock);
    chk("resp lag after", 32'(read_response), 32'd0);
    chk("idle read_data", read_data, 32'hdeadbeef);

    // mode 1 transfer left unread, then reset mid-byte
    bus_write(5'h04, 8'h01, 4'hf);
    cpha_m = 1'b1;
    bus_write(5'h08, 8'h66, 4'hf);
    exp_tx_q.push_back(8'h66);
    cs_low();
    spi_byte(8'h99, rx, 8, 0, 8'h00);
    cs_high();
    chk("m1 poci byte", 32'(rx), 32'(exp_tx_q.pop_front()));
    chk("m1 irq", 32'(irq), 32'd1);
    bus_write(5'h08, 8'h0f, 4'hf);
    cs_low();
    spi_byte(8'h96, rx, 3, 0, 8'h00);
    cyc(6);
    chk("pre-reset poci", 32'(poci), 32'd0);
    rw_address   = 5'h04;
    read_request = 1'b1;
    @(posedge clock);
    #2;
    reset = 1'b0;
    #1;
    chk("async irq", 32'(irq), 32'd0);
    chk("async poci", 32'(poci), 32'd1);
    chk("async read_data", read_data, 32'hdeadbeef);
    chk("async read_response", 32'(read_response), 32'd0);
    read_request = 1'b0;
    cs     = 1'b1;
    sclk   = 1'b0;
    pico   = 1'b0;
    cpha_m = 1'b0;
    cyc(3);
    reset = 1'b1;
    cyc(3);
    bus_read(5'h04, rd);
    chk("cpha after reset", rd, 32'd0);
    bus_read(5'h10, rd);
    chk("status after reset", rd, 32'd0);
    bus_write(5'h08, 8'he7, 4'hf);
    exp_tx_q.push_back(8'he7);
    cs_low();
    spi_byte(8'h18, rx, 8, 0, 8'h00);
    exp_rx_q.push_back(8'h18);
    cs_high();
    chk("post-reset poci byte", 32'(rx), 32'(exp_tx_q.pop_front()));
    bus_read(5'h0c, rd);
    chk("post-reset rdata", rd, 32'(exp_rx_q.pop_front()));

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule
